// File: rtl/hamming_pkg.sv
// Shared definitions for the (39,32) SECDED Hamming datapath: widths, the
// data-index <-> code-position mapping, syndrome and data-extract helpers.
package hamming_pkg;

    localparam int CODE_W = 39;
    localparam int DATA_W = 32;
    localparam int SYN_W  = 6;

    // Data bits fill every position >= 3 that is not a power of two, ascending.
    function automatic logic [SYN_W-1:0] data_pos(input int idx);
        int              cnt;
        logic [SYN_W-1:0] pos;
        cnt = 0;
        pos = '0;
        for (int p = 3; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) begin
                    pos = SYN_W'(p);
                end
                cnt++;
            end
        end
        return pos;
    endfunction

    // Only meaningful when pos is a data position.
    function automatic int pos_data(input int pos);
        int idx;
        idx = 0;
        for (int p = 3; p < CODE_W; p++) begin
            if (p < pos && (p & (p - 1)) != 0) begin
                idx++;
            end
        end
        return idx;
    endfunction

    function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] code);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (code[i]) begin
                s = s ^ SYN_W'(i);
            end
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int j = 0; j < DATA_W; j++) begin
            d[j] = code[data_pos(j)];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for one 39-bit codeword.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [SYN_W-1:0]  syn_o,
    output logic              par_o
);

    assign syn_o = syndrome(code_i);
    assign par_o = ^code_i;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED (39,32) check-and-correct pipeline with valid/ready flow.
// Define HAMMING_DEC_ERR_CNT_EN to add saturating single/double error counters.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic              clock,
  input  logic              resetn,
`ifdef HAMMING_DEC_ERR_CNT_EN
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  single_cnt,
  output logic [CNT_W-1:0]  double_cnt,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_single,
  output logic              out_double,
  output logic [SYN_W-1:0]  out_syndrome
);

  // Handshake: a word moves on valid & ready. Each stage advances when it is
  // empty or the stage after it advances; in_ready never looks at in_valid.
  logic              s1_valid_q;
  logic [CODE_W-1:0] s1_code_q;
  logic [SYN_W-1:0]  s1_syn_q;
  logic              s1_par_q;
  logic [SYN_W-1:0]  s1_syn_d;
  logic              s1_par_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_single_q;
  logic              out_double_q;
  logic [SYN_W-1:0]  out_syn_q;

  logic [DATA_W-1:0] out_data_d;
  logic              out_single_d;
  logic              out_double_d;
  logic [CODE_W-1:0] corr_code;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  hamming_syndrome u_syndrome (
    .code_i (in_code),
    .syn_o  (s1_syn_d),
    .par_o  (s1_par_d)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= in_code;
        s1_syn_q  <= s1_syn_d;
        s1_par_q  <= s1_par_d;
      end
    end
  end

  // Odd parity means an odd number of flips: correct if the syndrome names a
  // real position (0 meaning the parity bit itself), otherwise it is fatal.
  always_comb begin
    corr_code    = s1_code_q;
    out_single_d = 1'b0;
    out_double_d = 1'b0;
    if (s1_par_q) begin
      if (s1_syn_q <= SYN_W'(CODE_W - 1)) begin
        out_single_d = 1'b1;
        for (int i = 1; i < CODE_W; i++) begin
          if (s1_syn_q == SYN_W'(i)) begin
            corr_code[i] = ~s1_code_q[i];
          end
        end
      end else begin
        out_double_d = 1'b1;
      end
    end else if (s1_syn_q != '0) begin
      out_double_d = 1'b1;
    end
    out_data_d = extract_data(corr_code);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_single_q <= 1'b0;
      out_double_q <= 1'b0;
      out_syn_q    <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= out_data_d;
        out_single_q <= out_single_d;
        out_double_q <= out_double_d;
        out_syn_q    <= s1_syn_q;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_single   = out_single_q;
  assign out_double   = out_double_q;
  assign out_syndrome = out_syn_q;

`ifdef HAMMING_DEC_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] single_cnt_q;
  logic [CNT_W-1:0] double_cnt_q;
  logic             out_fire;

  assign out_fire = out_valid_q && out_ready;

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      single_cnt_q <= '0;
      double_cnt_q <= '0;
    end else if (cnt_clr) begin
      single_cnt_q <= '0;
      double_cnt_q <= '0;
    end else if (out_fire) begin
      if (out_single_q && single_cnt_q != CNT_MAX) begin
        single_cnt_q <= single_cnt_q + CNT_W'(1);
      end
      if (out_double_q && double_cnt_q != CNT_MAX) begin
        double_cnt_q <= double_cnt_q + CNT_W'(1);
      end
    end
  end

  assign single_cnt = single_cnt_q;
  assign double_cnt = double_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder: directed codewords, a random
// stream under random backpressure, stall/hold, mid-flight reset, counters.
module tb_hamming_secded_decoder;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [38:0] in_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_single;
  logic        out_double;
  logic [5:0]  out_syndrome;
`ifdef HAMMING_DEC_ERR_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [1:0]  single_cnt;
  logic [1:0]  double_cnt;
`endif

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_word;
  logic [39:0] held;
  logic [39:0] obs_word;
  int          pos_tab[32];
  bit          stream_done;

  assign obs_word = {out_data, out_single, out_double, out_syndrome};

  always #5 clock = ~clock;

  hamming_secded_decoder #(.CNT_W(2)) dut (
    .clock        (clock),
    .resetn       (resetn),
`ifdef HAMMING_DEC_ERR_CNT_EN
    .cnt_clr      (cnt_clr),
    .single_cnt   (single_cnt),
    .double_cnt   (double_cnt),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_single   (out_single),
    .out_double   (out_double),
    .out_syndrome (out_syndrome)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] tb_syn(input logic [38:0] c);
    logic [5:0] s;
    s = '0;
    for (int i = 1; i < 39; i++) begin
      if (c[i]) s = s ^ 6'(i);
    end
    return s;
  endfunction

  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [38:0] c;
    logic [5:0]  s;
    c = '0;
    for (int j = 0; j < 32; j++) c[pos_tab[j]] = d[j];
    s = tb_syn(c);
    for (int k = 0; k < 6; k++) c[1 << k] = s[k];
    c[0] = ^c;
    return c;
  endfunction

  // Expected {data, single, double, syndrome} for any received codeword.
  function automatic logic [39:0] model(input logic [38:0] c);
    logic [5:0]  s;
    logic        p;
    logic        sgl;
    logic        dbl;
    logic [38:0] fixed;
    logic [31:0] d;
    s = tb_syn(c);
    p = ^c;
    sgl = 1'b0;
    dbl = 1'b0;
    fixed = c;
    if (p) begin
      if (s == 6'd0) sgl = 1'b1;
      else if (s <= 6'd38) begin
        fixed[s] = ~fixed[s];
        sgl = 1'b1;
      end else dbl = 1'b1;
    end else if (s != 6'd0) dbl = 1'b1;
    for (int j = 0; j < 32; j++) d[j] = fixed[pos_tab[j]];
    return {d, sgl, dbl, s};
  endfunction

  // Leaves in_valid high so consecutive calls stream one word per cycle.
  task automatic send(input logic [38:0] code, input logic [39:0] exp);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_code  = code;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  always @(negedge clock) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", exp_q.size(), 1);
      end else begin
        exp_word = exp_q.pop_front();
        check("out_word", obs_word, exp_word);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [38:0] c;
    logic [38:0] junk;
    int          n;
    int          kind;
    int          p1;
    n = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        pos_tab[n] = p;
        n++;
      end
    end

    // Reset state
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", obs_word, 0);
    #2 resetn = 1'b1;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    @(posedge clock);
    #1;

    // Two-cycle latency on an empty pipe
    send(39'h0, 40'h0);
    in_valid = 1'b0;
    check("lat_cycle1", out_valid, 0);
    @(posedge clock);
    #1;
    check("lat_cycle2", out_valid, 1);
    drain("drain_latency");

    // Directed classification cases, streamed back to back
    send(39'h8,           {32'h0, 1'b1, 1'b0, 6'd3});
    send(39'h1,           {32'h0, 1'b1, 1'b0, 6'd0});
    send(39'h18,          {32'h1, 1'b0, 1'b1, 6'd7});
    send(39'h1_0000_0018, {32'h1, 1'b0, 1'b1, 6'd39});
    send(encode(32'hDEAD_BEEF) ^ (39'h1 << 38), {32'hDEAD_BEEF, 1'b1, 1'b0, 6'd38});
    send(encode(32'h1234_5678) ^ (39'h1 << 32), {32'h1234_5678, 1'b1, 1'b0, 6'd32});
    send(encode(32'hFFFF_FFFF),                 {32'hFFFF_FFFF, 1'b0, 1'b0, 6'd0});
    drain("drain_directed");

    // Random words with 0/1/2 flips or raw noise under random out_ready
    stream_done = 1'b0;
    fork
      begin
        for (int w = 0; w < 40; w++) begin
          c = encode($urandom);
          kind = $urandom_range(0, 3);
          p1 = $urandom_range(0, 38);
          if (kind >= 1) c[p1] = ~c[p1];
          if (kind == 2) begin
            p1 = (p1 + $urandom_range(1, 38)) % 39;
            c[p1] = ~c[p1];
          end
          if (kind == 3) c = {7'($urandom), 32'($urandom)};
          send(c, model(c));
        end
        in_valid = 1'b0;
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clock);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");

    // Backpressure: two words fill the pipe, junk offered while stalled
    out_ready = 1'b0;
    c = encode(32'hA5A5_0001);
    send(c, model(c));
    c = encode(32'h0F0F_0002) ^ 39'h40;
    send(c, model(c));
    junk = 39'h7F_FFFF_FFFF;
    in_code = junk;
    @(negedge clock);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_word", obs_word, exp_q[0]);
    held = obs_word;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_word", obs_word, held);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    c = encode(32'h0000_0003);
    send(c, model(c));
    c = encode(32'hC0DE_0004) ^ 39'h3;
    send(c, model(c));
    c = encode(32'h8000_0005);
    send(c, model(c));
    drain("drain_backpressure");

    // Reset with two words in flight: both are discarded
    out_ready = 1'b0;
    c = encode(32'h1111_1111);
    send(c, model(c));
    c = encode(32'h2222_2222);
    send(c, model(c));
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_word", obs_word, 0);
    exp_q.delete();
    @(posedge clock);
    #3 resetn = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("midrst_no_ghost", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);

`ifdef HAMMING_DEC_ERR_CNT_EN
    check("cnt_rst_single", single_cnt, 0);
    check("cnt_rst_double", double_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      c = encode($urandom) ^ (39'h1 << (k + 3));
      send(c, model(c));
    end
    send(39'h18, {32'h1, 1'b0, 1'b1, 6'd7});
    drain("drain_counters");
    check("cnt_single_sat", single_cnt, 3);
    check("cnt_double", double_cnt, 1);
    @(posedge clock);
    #1 cnt_clr = 1'b1;
    @(posedge clock);
    #1 cnt_clr = 1'b0;
    check("cnt_clr_single", single_cnt, 0);
    check("cnt_clr_double", double_cnt, 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
